// File: rtl/videomem_rd_req_gen_if.sv
// ---------------------------------------------------------------------------
// videomem_rd_req_gen_if
//   Request/return bus between the frame-buffer read-request generator and
//   the memory controller.
//
//   Signals:
//     mem_ready     controller -> generator  controller can take requests
//     read_req_ack  controller -> generator  request accepted this cycle
//     rdata_valid   controller -> generator  one returned data word
//     read_request  generator  -> controller burst read request
//     read_addr     generator  -> controller burst start word address
//
//   Handshake: a burst is transferred on every clock edge where
//   read_request && read_req_ack are both high. Once read_request is raised,
//   read_request and read_addr stay stable until that transfer happens.
//   read_req_ack while read_request is low has no effect. rdata_valid marks
//   one returned word; BURST_LEN such words complete one accepted burst.
// ---------------------------------------------------------------------------
interface videomem_rd_req_gen_if #(
    parameter int ADDR_W = 25
);
    logic              mem_ready;
    logic              read_req_ack;
    logic              rdata_valid;
    logic              read_request;
    logic [ADDR_W-1:0] read_addr;

    modport master (
        input  mem_ready,
        input  read_req_ack,
        input  rdata_valid,
        output read_request,
        output read_addr
    );

    modport slave (
        output mem_ready,
        output read_req_ack,
        output rdata_valid,
        input  read_request,
        input  read_addr
    );
endinterface

// File: rtl/videomem_rd_req_gen.sv
// ---------------------------------------------------------------------------
// videomem_rd_req_gen
//   Frame-buffer read-request generator for the display path. Walks a frame
//   of V_LINES lines, each H_WORDS words long, in bursts of BURST_LEN words,
//   starting at frame_base with line_stride between lines. Feeding is gated
//   by pixel FIFO hysteresis and by a limit on bursts still in flight.
//
//   Ports:
//     mem_clock    the only clock
//     reset_n      asynchronous active-low reset
//     vsync        vertical sync (asynchronous); falling edge restarts a frame
//     frame_base   frame start word address, sampled at restart
//     line_stride  address step between lines, sampled at restart
//     fifo_level   pixel FIFO fill level (mem_clock domain)
//     mem          request/return bus (master side)
//     frame_done   one-cycle pulse after the last burst of a frame is accepted
//     busy         high while in ACTIVE or HOLD
//     state_dbg    current FSM state (IDLE=0, ACTIVE=1, HOLD=2, DONE=3)
// ---------------------------------------------------------------------------
module videomem_rd_req_gen #(
    parameter int ADDR_W         = 25,
    parameter int H_WORDS        = 1280,
    parameter int V_LINES        = 720,
    parameter int BURST_LEN      = 8,
    parameter int LVL_W          = 2,
    parameter int THRESHOLD_LOW  = 1,
    parameter int THRESHOLD_HIGH = 3,
    parameter int MAX_OUTST      = 2
) (
    input  logic                  mem_clock,
    input  logic                  reset_n,
    input  logic                  vsync,
    input  logic [ADDR_W-1:0]     frame_base,
    input  logic [ADDR_W-1:0]     line_stride,
    input  logic [LVL_W-1:0]      fifo_level,
    videomem_rd_req_gen_if.master mem,
    output logic                  frame_done,
    output logic                  busy,
    output logic [1:0]            state_dbg
);
    localparam int HB    = H_WORDS / BURST_LEN;
    localparam int HC_W  = (HB > 1) ? $clog2(HB) : 1;
    localparam int VC_W  = $clog2(V_LINES + 1);
    localparam int BL_SH = $clog2(BURST_LEN);
    localparam int BT_W  = (BURST_LEN > 1) ? BL_SH : 1;

    localparam logic [HC_W-1:0] LAST_H    = HC_W'(HB - 1);
    localparam logic [VC_W-1:0] LAST_V    = VC_W'(V_LINES - 1);
    localparam logic [BT_W-1:0] LAST_BEAT = BT_W'(BURST_LEN - 1);
    localparam logic [3:0]      OUTST_LIM = 4'(MAX_OUTST);

    typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, HOLD = 2'd2, DONE = 2'd3} state_t;

    state_t            state, state_nx;
    logic [3:0]        vsync_sr;
    logic              feed;
    logic [3:0]        outstanding, outst_nx;
    logic [BT_W-1:0]   beat;
    logic [HC_W-1:0]   hcnt;
    logic [VC_W-1:0]   vcnt;
    logic [ADDR_W-1:0] line_base;
    logic [ADDR_W-1:0] stride_lat;
    logic              restart_pending;

    // Sampled falling edge of the synchronised vsync.
    logic restart;
    assign restart = (vsync_sr[3:2] == 2'b10);

    logic accept, beat_valid, wrap, reload_now, last_burst;
    logic can_issue, can_issue_b2b, reload, advance;

    assign accept     = (state == HOLD) && mem.read_req_ack;
    // Returned words with nothing in flight belong to no burst we know of.
    assign beat_valid = mem.rdata_valid && (outstanding != 4'd0);
    assign wrap       = beat_valid && (beat == LAST_BEAT);
    assign reload_now = restart || restart_pending;
    assign last_burst = (hcnt == LAST_H) && (vcnt == LAST_V);

    always_comb begin
        outst_nx = outstanding;
        if (accept && !wrap) begin
            outst_nx = outstanding + 4'd1;
        end else if (!accept && wrap) begin
            outst_nx = outstanding - 4'd1;
        end
    end

    assign can_issue     = mem.mem_ready && feed && (outstanding < OUTST_LIM);
    // Back-to-back decision sees the count as it will be after this accept.
    assign can_issue_b2b = mem.mem_ready && feed && (outst_nx < OUTST_LIM);

    // A restart outside HOLD reloads at once; in HOLD it waits for the accept,
    // and that accept consumes the held request without advancing the walk.
    assign reload  = (restart && (state != HOLD)) || (accept && reload_now);
    assign advance = accept && !reload_now;

    // FSM state register
    always_ff @(posedge mem_clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next state
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (restart) state_nx = ACTIVE;
            ACTIVE: if (can_issue) state_nx = HOLD;
            HOLD: begin
                if (accept) begin
                    if (reload_now)         state_nx = ACTIVE;
                    else if (last_burst)    state_nx = DONE;
                    else if (can_issue_b2b) state_nx = HOLD;
                    else                    state_nx = ACTIVE;
                end
            end
            DONE:   if (restart) state_nx = ACTIVE;
            default: state_nx = IDLE;
        endcase
    end

    // FSM outputs; the address is derived from the walk counters, which only
    // move on accept or reload, so it is stable for as long as HOLD lasts.
    always_comb begin
        mem.read_request = (state == HOLD);
        mem.read_addr    = line_base + (ADDR_W'(hcnt) << BL_SH);
        busy             = (state == ACTIVE) || (state == HOLD);
        state_dbg        = state;
    end

    // Synchroniser, feed hysteresis, in-flight tracking, frame walk.
    always_ff @(posedge mem_clock or negedge reset_n) begin
        if (!reset_n) begin
            vsync_sr        <= 4'b0000;
            feed            <= 1'b1;
            outstanding     <= 4'd0;
            beat            <= '0;
            hcnt            <= '0;
            vcnt            <= '0;
            line_base       <= '0;
            stride_lat      <= '0;
            restart_pending <= 1'b0;
            frame_done      <= 1'b0;
        end else begin
            vsync_sr <= {vsync_sr[2:0], vsync};

            if (32'(fifo_level) <= THRESHOLD_LOW) begin
                feed <= 1'b1;
            end else if (32'(fifo_level) >= THRESHOLD_HIGH) begin
                feed <= 1'b0;
            end

            outstanding <= outst_nx;
            if (beat_valid) begin
                beat <= wrap ? '0 : beat + BT_W'(1);
            end

            if (state == HOLD && restart && !accept) begin
                restart_pending <= 1'b1;
            end else if (accept) begin
                restart_pending <= 1'b0;
            end

            frame_done <= advance && last_burst;

            if (reload) begin
                line_base  <= frame_base;
                stride_lat <= line_stride;
                hcnt       <= '0;
                vcnt       <= '0;
            end else if (advance) begin
                if (hcnt == LAST_H) begin
                    hcnt      <= '0;
                    line_base <= line_base + stride_lat;
                    vcnt      <= vcnt + VC_W'(1);
                end else begin
                    hcnt <= hcnt + HC_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_videomem_rd_req_gen.sv
// ---------------------------------------------------------------------------
// tb_videomem_rd_req_gen
//   Bench for videomem_rd_req_gen with a small frame (64 words x 4 lines,
//   8-word bursts, at most 2 bursts in flight, base 0x100, stride 0x80).
//   Expected burst addresses are queued before each frame starts and
//   compared in order as bursts are accepted; a memory model returns
//   8 words per accepted burst when enabled.
// ---------------------------------------------------------------------------
module tb_videomem_rd_req_gen;
    localparam int AW = 25;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          vsync;
    logic [AW-1:0] frame_base;
    logic [AW-1:0] line_stride;
    logic [1:0]    fifo_level;
    logic          frame_done;
    logic          busy;
    logic [1:0]    state_dbg;

    videomem_rd_req_gen_if #(.ADDR_W(AW)) rd();

    videomem_rd_req_gen #(
        .ADDR_W(AW), .H_WORDS(64), .V_LINES(4), .BURST_LEN(8), .LVL_W(2),
        .THRESHOLD_LOW(1), .THRESHOLD_HIGH(3), .MAX_OUTST(2)
    ) dut (
        .mem_clock(clk), .reset_n(rst_n), .vsync(vsync),
        .frame_base(frame_base), .line_stride(line_stride),
        .fifo_level(fifo_level), .mem(rd), .frame_done(frame_done),
        .busy(busy), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    // scoreboard state
    int            checks = 0;
    int            failures = 0;
    logic [AW-1:0] exp_q[$];
    int            n_accepts = 0;
    int            n_frame_done = 0;
    int            beats_owed = 0;
    bit            auto_ack = 1'b0;
    bit            rdata_on = 1'b0;

    int lvl_seq[5] = '{0, 2, 3, 2, 1};
    int lvl_en[5]  = '{1, 1, 0, 0, 1};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Accept monitor (negedge) and memory/ack model (just after posedge).
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && rd.read_request && rd.read_req_ack) begin
                n_accepts++;
                if (rdata_on) beats_owed += 8;
                check("sb_underflow", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) check("accept_addr", 32'(rd.read_addr), 32'(exp_q.pop_front()));
            end
            if (frame_done) n_frame_done++;
            @(posedge clk);
            #1;
            if (beats_owed > 0) begin
                rd.rdata_valid = 1'b1;
                beats_owed--;
            end else begin
                rd.rdata_valid = 1'b0;
            end
            if (auto_ack) rd.read_req_ack = rd.read_request;
        end
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        auto_ack = 1'b0;
        rd.read_req_ack = 1'b0;
        beats_owed = 0;
        exp_q.delete();
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic pulse_vsync();
        vsync = 1'b1;
        tick(6);
        vsync = 1'b0;
    endtask

    task automatic wait_req(input string tag, input int budget);
        int n = 0;
        while (!rd.read_request && n < budget) begin
            tick(1);
            n++;
        end
        check({tag, "_req_seen"}, 32'(rd.read_request), 1);
    endtask

    task automatic ack_one(input string tag);
        wait_req(tag, 60);
        rd.read_req_ack = 1'b1;
        tick(1);
        rd.read_req_ack = 1'b0;
    endtask

    task automatic push_frame(input int base);
        for (int l = 0; l < 4; l++)
            for (int h = 0; h < 8; h++)
                exp_q.push_back(AW'(base + l * 32'h80 + h * 8));
    endtask

    // watchdog
    initial begin
        #400000;
        failures++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int start;
        int fd0;
        int n;
        vsync = 1'b0;
        frame_base = AW'(32'h100);
        line_stride = AW'(32'h80);
        fifo_level = 2'd0;
        rd.mem_ready = 1'b1;
        rd.read_req_ack = 1'b0;
        rd.rdata_valid = 1'b0;

        // reset state
        tick(3);
        check("rst_read_request", 32'(rd.read_request), 0);
        check("rst_read_addr", 32'(rd.read_addr), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        tick(5);
        check("idle_no_vsync_busy", 32'(busy), 0);

        // basic frame
        rdata_on = 1'b1;
        auto_ack = 1'b1;
        push_frame(32'h100);
        start = n_accepts;
        pulse_vsync();
        n = 0;
        while (n_frame_done == 0 && n < 3000) begin
            tick(1);
            n++;
        end
        tick(20);
        check("f1_accepts", 32'(n_accepts - start), 32);
        check("f1_frame_done", 32'(n_frame_done), 1);
        check("f1_req_low", 32'(rd.read_request), 0);
        check("f1_busy", 32'(busy), 0);
        check("f1_sb_empty", 32'(exp_q.size()), 0);

        // hold stability
        do_reset();
        rdata_on = 1'b1;
        exp_q.push_back(AW'(32'h100));
        pulse_vsync();
        wait_req("t2", 40);
        for (int i = 0; i < 10; i++) begin
            check("t2_hold_req", 32'(rd.read_request), 1);
            check("t2_hold_addr", 32'(rd.read_addr), 32'h100);
            rd.mem_ready = ~rd.mem_ready;
            tick(1);
        end
        rd.mem_ready = 1'b1;
        ack_one("t2_ack");
        tick(2);
        check("t2_sb_empty", 32'(exp_q.size()), 0);

        // outstanding limit
        do_reset();
        rdata_on = 1'b0;
        auto_ack = 1'b1;
        exp_q.push_back(AW'(32'h100));
        exp_q.push_back(AW'(32'h108));
        start = n_accepts;
        pulse_vsync();
        tick(30);
        check("t3_two_accepts", 32'(n_accepts - start), 2);
        check("t3_req_low", 32'(rd.read_request), 0);
        exp_q.push_back(AW'(32'h110));
        beats_owed = 8;
        n = 0;
        while ((n_accepts - start) < 3 && n < 40) begin
            tick(1);
            n++;
        end
        tick(20);
        check("t3_three_accepts", 32'(n_accepts - start), 3);
        check("t3_req_low_again", 32'(rd.read_request), 0);
        check("t3_sb_empty", 32'(exp_q.size()), 0);

        // hysteresis
        do_reset();
        rdata_on = 1'b1;
        auto_ack = 1'b1;
        push_frame(32'h100);
        pulse_vsync();
        for (int i = 0; i < 5; i++) begin
            fifo_level = 2'(lvl_seq[i]);
            tick(4);
            start = n_accepts;
            tick(int'($urandom_range(16, 24)));
            check($sformatf("t4_step%0d_lvl%0d", i, lvl_seq[i]), 32'((n_accepts - start) > 0), 32'(lvl_en[i]));
        end

        // vsync while a request is held
        do_reset();
        fifo_level = 2'd0;
        rdata_on = 1'b1;
        for (int h = 0; h < 6; h++) exp_q.push_back(AW'(32'h100 + h * 8));
        pulse_vsync();
        for (int i = 0; i < 5; i++) ack_one("t5_ack");
        wait_req("t5_held", 60);
        check("t5_addr_before", 32'(rd.read_addr), 32'h128);
        fd0 = n_frame_done;
        frame_base = AW'(32'h400);
        pulse_vsync();
        tick(6);
        check("t5_held_req", 32'(rd.read_request), 1);
        check("t5_held_addr", 32'(rd.read_addr), 32'h128);
        tick(3);
        ack_one("t5_ack_old");
        exp_q.push_back(AW'(32'h400));
        ack_one("t5_new_base");
        tick(2);
        check("t5_no_frame_done", 32'(n_frame_done - fd0), 0);
        check("t5_sb_empty", 32'(exp_q.size()), 0);

        // async reset while holding
        wait_req("t6", 60);
        check("t6_addr_held", 32'(rd.read_addr), 32'h408);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_async_req", 32'(rd.read_request), 0);
        check("t6_async_busy", 32'(busy), 0);
        beats_owed = 0;
        exp_q.delete();
        tick(2);
        rst_n = 1'b1;
        tick(10);
        check("t6_idle_busy", 32'(busy), 0);
        check("t6_idle_req", 32'(rd.read_request), 0);
        exp_q.push_back(AW'(32'h400));
        pulse_vsync();
        ack_one("t6_restart");
        tick(2);
        check("t6_sb_empty", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
